// File: rtl/imtx.sv
// UART transmitter that streams BRAM bytes from addr up to LAST_ADDR as 8N1 frames, LSB first.
// Define IMTX_PARITY_EN to send 8E1 frames (even parity bit after D7).
module imtx #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DIV_COUNTER = CLK_FREQ / BAUD_RATE,
  parameter int LAST_ADDR   = 16383,
  parameter int RD_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        start,
  input  logic [13:0] addr,
  input  logic [7:0]  dout,
  output logic        TxD,
  output logic        busy,
  output logic        ImTxComplete,
  output logic        ena_imtx,
  output logic [13:0] addr_imtx,
  output logic [2:0]  o_dbg_state
);

`ifdef IMTX_PARITY_EN
  localparam int N = 11;
`else
  localparam int N = 10;
`endif
  localparam int BCW = $clog2(DIV_COUNTER + 1);
  localparam int LCW = $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state, w_state_nx;
  logic [13:0]      r_addr1, w_addr1_nx;
  logic [N-1:0]     r_shreg, w_shreg_nx;
  logic [3:0]       r_bit, w_bit_nx;
  logic [BCW-1:0]   r_baud, w_baud_nx;
  logic [LCW-1:0]   r_lat, w_lat_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic [N-1:0]     w_frame;

`ifdef IMTX_PARITY_EN
  assign w_frame = {1'b1, ^dout, dout, 1'b0};
`else
  assign w_frame = {1'b1, dout, 1'b0};
`endif

  // start is a single-clock request, accepted only in IDLE with ena high;
  // busy stays high from acceptance until the FSM is back in IDLE.
  always_comb begin
    w_state_nx = r_state;
    w_addr1_nx = r_addr1;
    w_shreg_nx = r_shreg;
    w_bit_nx   = r_bit;
    w_baud_nx  = r_baud;
    w_lat_nx   = r_lat;
    w_busy_nx  = r_busy;
    w_done_nx  = r_done;
    case (r_state)
      S_IDLE: begin
        if (start && ena) begin
          w_addr1_nx = addr;
          w_done_nx  = 1'b0;
          w_busy_nx  = 1'b1;
          w_lat_nx   = '0;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (r_lat == LCW'(RD_LATENCY - 1)) begin
          w_lat_nx   = '0;
          w_state_nx = S_LOAD;
        end else begin
          w_lat_nx = r_lat + LCW'(1);
        end
      end
      S_LOAD: begin
        w_shreg_nx = w_frame;
        w_bit_nx   = '0;
        w_baud_nx  = '0;
        w_state_nx = S_SEND;
      end
      S_SEND: begin
        if (r_baud == BCW'(DIV_COUNTER - 1)) begin
          w_baud_nx = '0;
          if (r_bit == 4'(N - 1)) begin
            // End of the stop bit: decide whether another byte follows.
            if (!ena) begin
              w_busy_nx  = 1'b0;
              w_done_nx  = 1'b0;
              w_state_nx = S_IDLE;
            end else if (r_addr1 >= 14'(LAST_ADDR)) begin
              w_state_nx = S_DONE;
            end else begin
              w_addr1_nx = r_addr1 + 14'd1;
              w_lat_nx   = '0;
              w_state_nx = S_FETCH;
            end
          end else begin
            w_shreg_nx = {1'b1, r_shreg[N-1:1]};
            w_bit_nx   = r_bit + 4'd1;
          end
        end else begin
          w_baud_nx = r_baud + BCW'(1);
        end
      end
      S_DONE: begin
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr1 <= addr;
      r_shreg <= '1;
      r_bit   <= '0;
      r_baud  <= '0;
      r_lat   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr1 <= w_addr1_nx;
      r_shreg <= w_shreg_nx;
      r_bit   <= w_bit_nx;
      r_baud  <= w_baud_nx;
      r_lat   <= w_lat_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  assign TxD          = (r_state == S_SEND) ? r_shreg[0] : 1'b1;
  assign busy         = r_busy;
  assign ImTxComplete = r_done;
  assign ena_imtx     = ena;
  assign addr_imtx    = r_addr1;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_imtx.sv
// Directed bench for imtx: a BRAM model feeds the DUT, expected line bits are queued
// when a transfer is started and compared at the first and last clock of every bit.
module tb_imtx;
  localparam int DIV = 8;
`ifdef IMTX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        reset, ena, start;
  logic [13:0] addr;
  logic [7:0]  dout;
  logic        TxD, busy, ImTxComplete, ena_imtx;
  logic [13:0] addr_imtx;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [0:16383];
  logic [0:0]  exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  imtx #(.CLK_FREQ(800), .BAUD_RATE(100), .LAST_ADDR(5), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .ena(ena), .start(start), .addr(addr), .dout(dout),
    .TxD(TxD), .busy(busy), .ImTxComplete(ImTxComplete), .ena_imtx(ena_imtx),
    .addr_imtx(addr_imtx), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM
  always @(posedge clk) if (ena_imtx) dout <= mem[addr_imtx];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef IMTX_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic pulse_start(input logic [13:0] a);
    @(negedge clk);
    addr  = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_start(output int gap, output bit seen);
    gap  = 0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (TxD === 1'b0) begin
        seen = 1'b1;
        break;
      end
      gap++;
    end
    if (!seen) chk("start_bit_seen", {31'd0, TxD}, 32'd0);
  endtask

  // inject: 0 none, 1 start pulse at bit 4, 2 drop ena at bit 4, 3 reset at bit 4
  task automatic recv_frame(input logic [13:0] exp_addr, input int exp_gap, input int inject);
    int gap;
    bit seen;
    logic e;
    wait_start(gap, seen);
    if (!seen) return;
    if (exp_gap >= 0) chk("interframe_gap", gap, exp_gap);
    chk("addr_imtx", {18'd0, addr_imtx}, {18'd0, exp_addr});
    chk("busy_mid", {31'd0, busy}, 32'd1);
    chk("done_mid", {31'd0, ImTxComplete}, 32'd0);
    for (int i = 0; i < NB; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      if (i > 0) @(negedge clk);
      chk("bit_first_clk", {31'd0, TxD}, {31'd0, e});
      if (i == 4 && inject == 3) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_txd", {31'd0, TxD}, 32'd1);
        chk("rst_state", {29'd0, dbg_state}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, ImTxComplete}, 32'd0);
        chk("rst_addr", {18'd0, addr_imtx}, {18'd0, addr});
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      if (i == 4 && inject == 1) begin
        start = 1'b1;
        addr  = 14'd9;
      end
      if (i == 4 && inject == 2) ena = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (DIV - 2) @(negedge clk);
      chk("bit_last_clk", {31'd0, TxD}, {31'd0, e});
    end
  endtask

  task automatic check_done_seq();
    @(negedge clk);
    chk("done_not_early", {31'd0, ImTxComplete}, 32'd0);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("done_set", {31'd0, ImTxComplete}, 32'd1);
    chk("busy_clear", {31'd0, busy}, 32'd0);
    chk("idle_state", {29'd0, dbg_state}, 32'd0);
  endtask

  task automatic quiet_line(input string tag, input int cycles);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    chk(tag, lows, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    reset = 1'b1;
    ena   = 1'b1;
    start = 1'b0;
    addr  = 14'h0123;

    // Reset held 3 clocks
    repeat (3) @(negedge clk);
    chk("reset_txd", {31'd0, TxD}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, ImTxComplete}, 32'd0);
    chk("reset_addr", {18'd0, addr_imtx}, 32'h0123);
    chk("reset_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_txd", {31'd0, TxD}, 32'd1);

    // Single byte at the last address
    mem[5] = 8'hA5;
    push_frame(mem[5]);
    pulse_start(14'd5);
    recv_frame(14'd5, -1, 0);
    check_done_seq();

    // Four-byte block, a stray start during the second frame
    mem[2] = 8'h11; mem[3] = 8'h22; mem[4] = 8'h33; mem[5] = 8'h44;
    for (int a = 2; a <= 5; a++) push_frame(mem[a]);
    pulse_start(14'd2);
    chk("done_clr_on_start", {31'd0, ImTxComplete}, 32'd0);
    recv_frame(14'd2, -1, 0);
    recv_frame(14'd3, 2, 1);
    recv_frame(14'd4, 2, 0);
    recv_frame(14'd5, 2, 0);
    check_done_seq();
    chk("addr_after_block", {18'd0, addr_imtx}, 32'd5);

    // ena drops mid-frame: frame completes, nothing further fetched
    push_frame(mem[2]);
    pulse_start(14'd2);
    recv_frame(14'd2, -1, 2);
    @(negedge clk);
    chk("abort_state", {29'd0, dbg_state}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, ImTxComplete}, 32'd0);
    chk("ena_imtx_low", {31'd0, ena_imtx}, 32'd0);
    quiet_line("abort_line_idle", 20);

    // start with ena low is ignored
    pulse_start(14'd3);
    repeat (4) @(negedge clk);
    chk("noena_busy", {31'd0, busy}, 32'd0);
    chk("noena_state", {29'd0, dbg_state}, 32'd0);
    quiet_line("noena_line_idle", 10);
    ena = 1'b1;

    // Start beyond the last address sends exactly one byte
    mem[9] = 8'h07;
    push_frame(mem[9]);
    pulse_start(14'd9);
    recv_frame(14'd9, -1, 0);
    check_done_seq();
    quiet_line("beyond_last_one_byte", 30);

    // Reset during bit 4
    push_frame(mem[5]);
    pulse_start(14'd5);
    recv_frame(14'd5, -1, 3);
    quiet_line("post_reset_idle", 30);
    chk("post_reset_done", {31'd0, ImTxComplete}, 32'd0);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
